// File: rtl/mc_ctrl_if.sv
// Control-unit bus: datapath-facing inputs (IR, debug controls) and every
// stage-register / architectural write enable plus status and counters.
interface mc_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      instr;
  logic             halt_req;
  logic             step;
  logic             ir_we;
  logic             dec_we;
  logic             alu_we;
  logic             mdr_we;
  logic             pc_we;
  logic             rf_we;
  logic             mem_we;
  logic             halted;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret;

  // Datapath / debugger side
  modport master (
    output instr, halt_req, step,
    input  ir_we, dec_we, alu_we, mdr_we, pc_we, rf_we, mem_we,
    input  halted, illegal, state, cycle_cnt, instret
  );

  // Control unit side
  modport slave (
    input  instr, halt_req, step,
    output ir_we, dec_we, alu_we, mdr_we, pc_we, rf_we, mem_we,
    output halted, illegal, state, cycle_cnt, instret
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control unit: IF/ID/EX/MEM/WB sequencing with memory
// wait states, debug halt/single-step, illegal-opcode trap and counters.
module mc_ctrl_fsm #(
  parameter int unsigned IMEM_LAT = 0,
  parameter int unsigned DMEM_LAT = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILL
  } cls_t;

  localparam logic [3:0] IMEM_W = 4'(IMEM_LAT);
  localparam logic [3:0] DMEM_W = 4'(DMEM_LAT);

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_after_retire;
  logic [3:0]       r_wait;
  logic             r_step_mode;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret;
  cls_t             w_cls;
  logic             w_retire;
  logic             w_unused_instr;

  assign w_unused_instr = ^bus.instr[31:7];

  // Opcode class decode from the latched IR
  always_comb begin
    w_cls = C_ILL;
    case (bus.instr[6:0])
      7'b0110011, 7'b0010011,
      7'b0110111, 7'b0010111: w_cls = C_ALU;
      7'b0000011:             w_cls = C_LOAD;
      7'b0100011:             w_cls = C_STORE;
      7'b1100011:             w_cls = C_BRANCH;
      7'b1101111, 7'b1100111: w_cls = C_JUMP;
      default:                w_cls = C_ILL;
    endcase
  end

  // Stores retire at the end of MEM; everything else retires in WB
  assign w_retire = (r_state == S_WB) ||
                    (r_state == S_MEM && r_wait == DMEM_W && w_cls == C_STORE);

  assign w_after_retire = (bus.halt_req || r_step_mode) ? S_HALT : S_IF;

  // State register and wait counter (counter only runs in IF and MEM)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IF;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_wait <= '0;
      else if (r_state == S_IF || r_state == S_MEM)
        r_wait <= r_wait + 4'd1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IF:   if (r_wait == IMEM_W) w_state_nxt = S_ID;
      S_ID:   w_state_nxt = (w_cls == C_ILL) ? S_HALT : S_EX;
      S_EX:   w_state_nxt = (w_cls == C_LOAD || w_cls == C_STORE) ? S_MEM : S_WB;
      S_MEM:  if (r_wait == DMEM_W)
                w_state_nxt = (w_cls == C_STORE) ? w_after_retire : S_WB;
      S_WB:   w_state_nxt = w_after_retire;
      S_HALT: if (!r_illegal && (bus.step || !bus.halt_req)) w_state_nxt = S_IF;
      default: w_state_nxt = S_IF;
    endcase
  end

  // Stage-register and write enables, decoded from state, wait count and class
  always_comb begin
    bus.ir_we  = 1'b0;
    bus.dec_we = 1'b0;
    bus.alu_we = 1'b0;
    bus.mdr_we = 1'b0;
    bus.pc_we  = 1'b0;
    bus.rf_we  = 1'b0;
    bus.mem_we = 1'b0;
    case (r_state)
      S_IF:  bus.ir_we  = (r_wait == IMEM_W);
      S_ID:  bus.dec_we = (w_cls != C_ILL);
      S_EX:  bus.alu_we = 1'b1;
      S_MEM: if (r_wait == DMEM_W) begin
               bus.mdr_we = (w_cls == C_LOAD);
               bus.mem_we = (w_cls == C_STORE);
               bus.pc_we  = (w_cls == C_STORE);
             end
      S_WB:  begin
               bus.pc_we = 1'b1;
               bus.rf_we = (w_cls == C_ALU) || (w_cls == C_LOAD) || (w_cls == C_JUMP);
             end
      default: ;
    endcase
  end

  // Sticky illegal flag, single-step latch and performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal   <= 1'b0;
      r_step_mode <= 1'b0;
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else begin
      if (r_state == S_ID && w_cls == C_ILL)
        r_illegal <= 1'b1;
      if (w_retire)
        r_step_mode <= 1'b0;
      else if (r_state == S_HALT && !r_illegal && bus.step)
        r_step_mode <= 1'b1;
      if (r_state != S_HALT)
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire)
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign bus.halted    = (r_state == S_HALT);
  assign bus.illegal   = r_illegal;
  assign bus.state     = r_state;
  assign bus.cycle_cnt = r_cycle_cnt;
  assign bus.instret   = r_instret;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: scenarios are planned up front from a per-class
// cycle-trace model, then replayed against the DUT and compared cycle by cycle.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;
  localparam int unsigned IL = 1;
  localparam int unsigned DL = 2;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(CW)) bus ();
  mc_ctrl_fsm #(.IMEM_LAT(IL), .DMEM_LAT(DL), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // en = {ir, dec, alu, mdr, pc, rf, mem}
  typedef struct packed { logic [2:0] st; logic [6:0] en; } cyc_t;
  typedef struct packed {
    logic [2:0] st; logic [6:0] en; logic hl; logic il;
    logic [CW-1:0] cyc; logic [CW-1:0] ret;
  } obs_t;

  int checks = 0;
  int errors = 0;

  cyc_t        tr_q[$];
  obs_t        ex_q[$];
  obs_t        got_q[$];
  logic [31:0] in_q[$];
  logic        hq_q[$];
  logic        sp_q[$];
  logic [31:0] last_ins;
  logic        cur_hq;
  logic [CW-1:0] m_cyc, m_ret;
  logic        m_ill;

  logic [6:0]  legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
  logic [31:0] dir_prog [3] = '{32'h002081B3, 32'h0000A183, 32'h0020A023};
  int unsigned dir_lat  [3] = '{4 + IL, 5 + IL + DL, 4 + IL + DL};
  localparam logic [31:0] ADD = 32'h002081B3;

  // 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 illegal
  function automatic int kind(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return 0;
      7'b0000011: return 1;
      7'b0100011: return 2;
      7'b1100011: return 3;
      7'b1101111, 7'b1100111: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic cyc_t mk(input logic [2:0] s, input logic [6:0] e);
    cyc_t c;
    c.st = s;
    c.en = e;
    return c;
  endfunction

  function automatic cyc_t if0();
    return mk(3'd0, (IL == 0) ? 7'b1000000 : 7'b0000000);
  endfunction

  // Cycle-by-cycle trace of one instruction from first IF cycle to retire
  function automatic void build_trace(input logic [6:0] op);
    int k;
    k = kind(op);
    tr_q.delete();
    for (int unsigned i = 0; i < IL; i++) tr_q.push_back(mk(3'd0, 7'b0000000));
    tr_q.push_back(mk(3'd0, 7'b1000000));
    if (k == 5) begin
      tr_q.push_back(mk(3'd1, 7'b0000000));
      return;
    end
    tr_q.push_back(mk(3'd1, 7'b0100000));
    tr_q.push_back(mk(3'd2, 7'b0010000));
    if (k == 1 || k == 2) begin
      for (int unsigned i = 0; i < DL; i++) tr_q.push_back(mk(3'd3, 7'b0000000));
      if (k == 1) tr_q.push_back(mk(3'd3, 7'b0001000));
      else        tr_q.push_back(mk(3'd3, 7'b0000101));
    end
    if (k == 3)      tr_q.push_back(mk(3'd4, 7'b0000100));
    else if (k != 2) tr_q.push_back(mk(3'd4, 7'b0000110));
  endfunction

  function automatic void zero_model();
    m_cyc = '0;
    m_ret = '0;
    m_ill = 1'b0;
  endfunction

  function automatic obs_t expect_of(input cyc_t c);
    obs_t o;
    o.st = c.st; o.en = c.en; o.hl = (c.st == 3'd5); o.il = m_ill;
    o.cyc = m_cyc; o.ret = m_ret;
    return o;
  endfunction

  function automatic void plan_cycle(input cyc_t c, input logic [31:0] ins,
                                     input logic hq, input logic sp);
    ex_q.push_back(expect_of(c));
    if (c.st != 3'd5) m_cyc = m_cyc + 1'b1;
    if (c.en[2])      m_ret = m_ret + 1'b1;
    if (c.st == 3'd1 && c.en == 7'd0) m_ill = 1'b1;
    in_q.push_back(ins);
    hq_q.push_back(hq);
    sp_q.push_back(sp);
    last_ins = ins;
  endfunction

  function automatic void plan_halt(input logic hq, input logic sp);
    plan_cycle(mk(3'd5, 7'd0), last_ins, hq, sp);
  endfunction

  // mode 0: halt_req held at cur_hq; 1: random halt_req/step; 2: halt_req rises at EX
  function automatic logic plan_instr(input logic [31:0] ins, input int mode);
    logic hq_ret;
    logic hq, sp;
    hq_ret = 1'b0;
    build_trace(ins[6:0]);
    foreach (tr_q[k]) begin
      case (mode)
        1:       begin hq = 1'($urandom); sp = 1'($urandom); end
        2:       begin hq = (tr_q[k].st >= 3'd2); sp = 1'b0; end
        default: begin hq = cur_hq; sp = 1'b0; end
      endcase
      plan_cycle(tr_q[k], ins, hq, sp);
      if (tr_q[k].en[2]) hq_ret = hq;
    end
    return hq_ret;
  endfunction

  function automatic void clear_plan();
    ex_q.delete(); in_q.delete(); hq_q.delete(); sp_q.delete();
  endfunction

  function automatic obs_t obs_now();
    obs_t o;
    o.st  = bus.state;
    o.en  = {bus.ir_we, bus.dec_we, bus.alu_we, bus.mdr_we, bus.pc_we, bus.rf_we, bus.mem_we};
    o.hl  = bus.halted;
    o.il  = bus.illegal;
    o.cyc = bus.cycle_cnt;
    o.ret = bus.instret;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d en=%b halted=%b ill=%b cyc=%0d ret=%0d",
                     o.st, o.en, o.hl, o.il, o.cyc, o.ret);
  endfunction

  // Replays the first n planned cycles, capturing outputs mid-cycle
  task automatic execute(input int n);
    got_q.delete();
    for (int k = 0; k < n; k++) begin
      bus.instr    = in_q[k];
      bus.halt_req = hq_q[k];
      bus.step     = sp_q[k];
      @(negedge clk);
      got_q.push_back(obs_now());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.halt_req = 1'b0;
    bus.step     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    zero_model();
  endtask

  task automatic test_reset();
    obs_t o, e;
    bus.instr = ADD; bus.halt_req = 1'b0; bus.step = 1'b0;
    rst = 1'b1;
    #2;
    zero_model();
    e = expect_of(if0());
    o = obs_now();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_t0: got %s, want %s", fmt(o), fmt(e)); end
    repeat (3) @(posedge clk);
    #1;
    o = obs_now();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_held: got %s, want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_directed();
    int ret_at;
    obs_t last;
    foreach (dir_prog[p]) begin
      do_reset();
      clear_plan();
      cur_hq = 1'b0;
      void'(plan_instr(dir_prog[p], 0));
      plan_cycle(if0(), dir_prog[p], 1'b0, 1'b0);
      execute(ex_q.size());
      ret_at = -1;
      foreach (got_q[k]) begin
        checks++;
        if (got_q[k] !== ex_q[k]) begin
          errors++;
          $display("FAIL directed%0d[%0d]: got %s, want %s", p, k, fmt(got_q[k]), fmt(ex_q[k]));
        end
        if (got_q[k].en[2] && ret_at < 0) ret_at = k + 1;
      end
      checks++;
      if (ret_at != int'(dir_lat[p])) begin
        errors++;
        $display("FAIL latency%0d: got retire cycle %0d, want %0d", p, ret_at, dir_lat[p]);
      end
      last = got_q[got_q.size() - 1];
      checks++;
      if (last.ret !== CW'(1) || last.cyc !== CW'(dir_lat[p])) begin
        errors++;
        $display("FAIL counters%0d: got instret=%0d cycle_cnt=%0d, want instret=1 cycle_cnt=%0d",
                 p, last.ret, last.cyc, dir_lat[p]);
      end
    end
  endtask

  task automatic test_halt_step();
    do_reset();
    clear_plan();
    void'(plan_instr(32'h00208463, 2));
    repeat (5) plan_halt(1'b1, 1'b0);
    plan_halt(1'b1, 1'b1);
    cur_hq = 1'b1;
    void'(plan_instr(ADD, 0));
    repeat (3) plan_halt(1'b1, 1'b0);
    plan_halt(1'b0, 1'b1);
    cur_hq = 1'b0;
    void'(plan_instr(ADD, 0));
    plan_halt(1'b0, 1'b0);
    void'(plan_instr(ADD, 0));
    execute(ex_q.size());
    foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== ex_q[k]) begin
        errors++;
        $display("FAIL halt_step[%0d]: got %s, want %s", k, fmt(got_q[k]), fmt(ex_q[k]));
      end
    end
  endtask

  task automatic test_illegal();
    obs_t o, e;
    do_reset();
    clear_plan();
    cur_hq = 1'b0;
    void'(plan_instr(32'h0000007F, 0));
    repeat (10) plan_halt(1'($urandom), 1'($urandom));
    execute(ex_q.size());
    foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== ex_q[k]) begin
        errors++;
        $display("FAIL illegal[%0d]: got %s, want %s", k, fmt(got_q[k]), fmt(ex_q[k]));
      end
    end
    rst = 1'b1;
    #1;
    zero_model();
    e = expect_of(if0());
    o = obs_now();
    checks++;
    if (o !== e) begin errors++; $display("FAIL illegal_clear: got %s, want %s", fmt(o), fmt(e)); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    do_reset();
    clear_plan();
    cur_hq = 1'b0;
    void'(plan_instr(ADD, 0));
    execute(IL + 2);
    foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== ex_q[k]) begin
        errors++;
        $display("FAIL async_pre[%0d]: got %s, want %s", k, fmt(got_q[k]), fmt(ex_q[k]));
      end
    end
    o = obs_now();
    checks++;
    if (o !== ex_q[IL + 2]) begin
      errors++; $display("FAIL async_in_ex: got %s, want %s", fmt(o), fmt(ex_q[IL + 2]));
    end
    #1 rst = 1'b1;
    #1;
    zero_model();
    e = expect_of(if0());
    o = obs_now();
    checks++;
    if (o !== e) begin errors++; $display("FAIL async_reset: got %s, want %s", fmt(o), fmt(e)); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_plan();
    void'(plan_instr(ADD, 0));
    execute(ex_q.size());
    foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== ex_q[k]) begin
        errors++;
        $display("FAIL async_resume[%0d]: got %s, want %s", k, fmt(got_q[k]), fmt(ex_q[k]));
      end
    end
  endtask

  task automatic test_random();
    logic step_mode;
    logic hq;
    logic [31:0] r;
    do_reset();
    clear_plan();
    step_mode = 1'b0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      hq = plan_instr({r[31:7], legal_ops[$urandom_range(0, 8)]}, 1);
      if (hq || step_mode) begin
        step_mode = 1'b0;
        repeat ($urandom_range(0, 3)) plan_halt(1'b1, 1'b0);
        if ($urandom_range(0, 1) == 1) begin
          plan_halt(1'($urandom), 1'b1);
          step_mode = 1'b1;
        end else begin
          plan_halt(1'b0, 1'b0);
        end
      end else begin
        step_mode = 1'b0;
      end
    end
    execute(ex_q.size());
    foreach (got_q[k]) begin
      checks++;
      if (got_q[k] !== ex_q[k]) begin
        errors++;
        $display("FAIL random[%0d]: got %s, want %s", k, fmt(got_q[k]), fmt(ex_q[k]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_halt_step();
    test_illegal();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by time limit, want completion");
    $fatal(1, "time limit");
  end
endmodule
